// File: rtl/aes_enc_pkg.sv
// Shared types, S-box, round constants and GF(2^8) helpers for the iterative AES-128 encryptor.
package aes_enc_pkg;

    typedef enum logic [2:0] {IDLE, SUB, SHIFT, MIX, ADDK, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes a0..a3 run top row to bottom row, a0 in [31:24].
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_enc_if.sv
// START/DONE handshake bundle between the AES host and the encryptor core.
interface aes_enc_if;
    logic         AES_START;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_PLAIN;
    logic [127:0] AES_MSG_ENC;
    logic         AES_DONE;

    modport master (output AES_START, AES_KEY, AES_MSG_PLAIN,
                    input  AES_MSG_ENC, AES_DONE);
    modport slave  (input  AES_START, AES_KEY, AES_MSG_PLAIN,
                    output AES_MSG_ENC, AES_DONE);
endinterface

// File: rtl/aes_key_step.sv
// One step of the AES-128 key expansion: derives the next round key from the current one.
module aes_key_step
    import aes_enc_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

    assign w0  = rk_in[127:96];
    assign w1  = rk_in[95:64];
    assign w2  = rk_in[63:32];
    assign w3  = rk_in[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign rk_out = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor: one transformation per cycle, MixColumns one column per cycle,
// round keys expanded on the fly alongside SubBytes.
module aes_encrypt_core
    import aes_enc_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input logic     CLK,
    input logic     RESET,
    aes_enc_if.slave bus
);
    if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
        $error("aes_encrypt_core supports only NUM_ROUNDS = 10");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t       state;
    logic [127:0] st, rk, enc_q;
    logic [3:0]   round;
    logic [1:0]   col;
    logic         done_q;
    logic [127:0] sub_st, shift_st, rk_next;
    logic [7:0]   rcon_sel;

    always_comb begin
        sub_st = '0;
        for (int i = 0; i < 16; i++)
            sub_st[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
    end

    // Row r of column c takes the byte from column (c + r) mod 4.
    always_comb begin
        shift_st = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shift_st[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
    end

    always_comb begin
        rcon_sel = 8'h00;
        if (round != 4'd0 && round <= 4'd10)
            rcon_sel = RCON[round - 4'd1];
    end

    aes_key_step u_key_step (
        .rk_in  (rk),
        .rcon   (rcon_sel),
        .rk_out (rk_next)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            st     <= '0;
            rk     <= '0;
            round  <= '0;
            col    <= '0;
            enc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.AES_START) begin
                        st    <= bus.AES_MSG_PLAIN ^ bus.AES_KEY;
                        rk    <= bus.AES_KEY;
                        round <= 4'd1;
                        state <= SUB;
                    end
                end
                SUB: begin
                    st    <= sub_st;
                    rk    <= rk_next;
                    state <= SHIFT;
                end
                SHIFT: begin
                    st <= shift_st;
                    if (round == LAST_ROUND) begin
                        state <= ADDK;
                    end else begin
                        col   <= 2'd0;
                        state <= MIX;
                    end
                end
                MIX: begin
                    st[127-32*col -: 32] <= mix_column(st[127-32*col -: 32]);
                    col <= col + 2'd1;
                    if (col == 2'd3)
                        state <= ADDK;
                end
                ADDK: begin
                    st <= st ^ rk;
                    if (round == LAST_ROUND) begin
                        enc_q  <= st ^ rk;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        round <= round + 4'd1;
                        state <= SUB;
                    end
                end
                DONE: begin
                    // A held START keeps the result parked; a new block needs a fresh rising request.
                    if (!bus.AES_START) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.AES_MSG_ENC = enc_q;
    assign bus.AES_DONE    = done_q;
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core with a queue of expected ciphertexts.
module tb_aes_encrypt_core;
    import aes_enc_pkg::*;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R1_ST  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] R10_RK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    logic rst;
    aes_enc_if bus();

    aes_encrypt_core #(.NUM_ROUNDS(10)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [127:0] exp_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [127:0] key, input logic [127:0] plain,
                            input logic [127:0] exp);
        @(negedge clk);
        bus.AES_KEY       = key;
        bus.AES_MSG_PLAIN = plain;
        bus.AES_START     = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic wait_done(input string tag, input bit probe, input int mangle_at);
        int e;
        bit early;
        logic [127:0] enc0;
        logic [127:0] exp;
        e     = 0;
        early = 1'b0;
        enc0  = bus.AES_MSG_ENC;
        while (e < 200) begin
            @(posedge clk);
            #1;
            e++;
            if (probe && e == 8)  chk({tag, "_st_round1"}, dut.st, R1_ST);
            if (probe && e == 65) chk({tag, "_rk_round10"}, dut.rk, R10_RK);
            if (e == mangle_at) begin
                bus.AES_START     = 1'b0;
                bus.AES_KEY       = ~bus.AES_KEY;
                bus.AES_MSG_PLAIN = {bus.AES_MSG_PLAIN[63:0], bus.AES_MSG_PLAIN[127:64]};
            end
            if (bus.AES_DONE) break;
            if (bus.AES_MSG_ENC !== enc0) early = 1'b1;
        end
        chk({tag, "_latency"}, 128'(e), 128'd67);
        chk({tag, "_enc_stable"}, 128'(early), 128'd0);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 128'd0, 128'd1);
        end else begin
            exp = exp_q.pop_front();
            chk({tag, "_enc"}, bus.AES_MSG_ENC, exp);
        end
    endtask

    initial begin
        int hold_bad;
        logic [127:0] dropped;
        rst               = 1'b1;
        bus.AES_START     = 1'b0;
        bus.AES_KEY       = '0;
        bus.AES_MSG_PLAIN = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 128'(bus.AES_DONE), 128'd0);
        chk("rst_enc", bus.AES_MSG_ENC, 128'd0);
        chk("rst_state", 128'(dut.state), 128'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 App.B with internal probes, START held through DONE
        start_op(K1, P1, C1);
        wait_done("v1", 1'b1, 0);
        hold_bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!bus.AES_DONE || dut.state != DONE) hold_bad++;
        end
        chk("hold_done", 128'(hold_bad), 128'd0);
        @(negedge clk);
        bus.AES_START = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_state", 128'(dut.state), 128'(IDLE));
        chk("drop_done", 128'(bus.AES_DONE), 128'd0);
        chk("drop_enc_held", bus.AES_MSG_ENC, C1);
        repeat (5) @(posedge clk);
        #1;
        chk("idle_enc_held", bus.AES_MSG_ENC, C1);

        // FIPS-197 C.1 after a fresh rising START
        start_op(K2, P2, C2);
        wait_done("v2", 1'b0, 0);

        // Inputs disturbed mid-operation
        @(negedge clk);
        bus.AES_START = 1'b0;
        repeat (2) @(negedge clk);
        start_op(K1, P1, C1);
        wait_done("v1_mangled", 1'b0, 10);

        // Asynchronous reset in the middle of a block
        @(negedge clk);
        bus.AES_START = 1'b0;
        repeat (2) @(negedge clk);
        start_op(K2, P2, C2);
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_done", 128'(bus.AES_DONE), 128'd0);
        chk("arst_enc", bus.AES_MSG_ENC, 128'd0);
        chk("arst_state", 128'(dut.state), 128'(IDLE));
        if (exp_q.size() != 0) dropped = exp_q.pop_front();
        @(negedge clk);
        bus.AES_START = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start_op(K1, P1, C1);
        wait_done("v1_after_rst", 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
